// File: rtl/seq_mult32_pkg.sv
// Shared types and sizing for the sequential 32x32 shift-add multiplier.
package seq_mult32_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage

// File: rtl/seq_mult32_add32_cout.sv
// Purely combinational 32-bit ripple-carry adder with carry-out and no carry-in.
module add32_cout
   import seq_mult32_pkg::*;
(
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b
);

   logic [WIDTH:0] carry_s;

   // Bit-serial carry chain, one full adder per bit.
   always_comb begin
      carry_s    = {(WIDTH+1){1'b0}};
      sum        = {WIDTH{1'b0}};
      carry_s[0] = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i]         = a[i] ^ b[i] ^ carry_s[i];
         carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
      end
      cout = carry_s[WIDTH];
   end

endmodule

// File: rtl/seq_mult32.sv
// Sequential 32x32->64 unsigned shift-add multiplier with valid/ready handshakes.
// Optional zero-operand shortcut enabled by defining SEQ_MULT32_EARLY_TERM_EN.
module seq_mult32
   import seq_mult32_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   prod,
   output logic                 busy
);

   mult_state_t      state_r;
   mult_state_t      next_state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] m_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] addend_s;
   logic [WIDTH-1:0] sum_s;
   logic             cout_s;
   logic             zero_s;

   assign addend_s = q_r[0] ? m_r : {WIDTH{1'b0}};

   add32_cout u_add (
      .sum  (sum_s),
      .cout (cout_s),
      .a    (acc_r),
      .b    (addend_s)
   );

`ifdef SEQ_MULT32_EARLY_TERM_EN
   assign zero_s = (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});
`else
   assign zero_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               next_state_s = zero_s ? DONE : RUN;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == CNT_W'(WIDTH - 1)) begin
               next_state_s = DONE;
            end else begin
               next_state_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = DONE;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Datapath: the carry lands in acc_r[31] so the 65-bit shift never loses it.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_r   <= {WIDTH{1'b0}};
         acc_r <= {WIDTH{1'b0}};
         q_r   <= {WIDTH{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  m_r   <= a;
                  q_r   <= zero_s ? {WIDTH{1'b0}} : b;
                  acc_r <= {WIDTH{1'b0}};
                  cnt_r <= {CNT_W{1'b0}};
               end
            end
            RUN: begin
               acc_r <= {cout_s, sum_s[WIDTH-1:1]};
               q_r   <= {sum_s[0], q_r[WIDTH-1:1]};
               cnt_r <= cnt_r + CNT_W'(1);
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // Output decode.
   always_comb begin
      in_ready  = (state_r == IDLE) && !rst;
      out_valid = (state_r == DONE);
      busy      = (state_r == RUN) || (state_r == DONE);
      prod      = {acc_r, q_r};
   end

endmodule

// File: tb/tb_seq_mult32.sv
// Scoreboard bench for seq_mult32: driver pushes expected products, a monitor pops on output.
module tb_seq_mult32;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] prod;
   logic        busy;

   typedef struct {
      logic [63:0] p;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t sb[$];
   int   errors  = 0;
   int   checks  = 0;
   int   cyc     = 0;
   logic prev_ov = 1'b0;

   seq_mult32 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .prod      (prod),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Edges from the accept edge until out_valid is first seen.
   function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef SEQ_MULT32_EARLY_TERM_EN
      return ((x == 32'd0) || (y == 32'd0)) ? 0 : 32;
`else
      return 32;
`endif
   endfunction

   // Monitor: compares every presented product against the scoreboard head.
   always @(negedge clk) begin
      if (out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 64'd1, 64'd0);
         end else begin
            check("prod", prod, sb[0].p);
            check("in_ready_in_done", 64'(in_ready), 64'd0);
            if (!prev_ov) check("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
            if (out_ready) void'(sb.pop_front());
         end
      end
      prev_ov <= out_valid;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input bit keep);
      int n = 0;
      while (!in_ready && n < 200) begin
         step();
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 64'd0, 64'd1);
         return;
      end
      check("busy_at_accept", 64'(busy), 64'd0);
      a        = x;
      b        = y;
      in_valid = 1'b1;
      sb.push_back('{exp, exp_lat(x, y), cyc + 1});
      step();
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 300) begin
         step();
         n++;
      end
      if (sb.size() != 0 || !in_ready) check("drain_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int n;
      logic [31:0] x;
      logic [31:0] y;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = 32'd0;
      b         = 32'd0;
      out_ready = 1'b1;
      step();
      step();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_prod", prod, 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      step();
      check("in_ready_after_rst", 64'(in_ready), 64'd1);

      issue(32'd3, 32'd5, 64'h0F, 1'b0);
      drain();
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
      drain();

      // Backpressure: product must hold for six cycles.
      out_ready = 1'b0;
      issue(32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E_242D2080, 1'b0);
      n = 0;
      while (!out_valid && n < 100) begin
         step();
         n++;
      end
      check("hold_out_valid_rise", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_out_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      step();
      check("post_hs_out_valid", 64'(out_valid), 64'd0);
      check("post_hs_in_ready", 64'(in_ready), 64'd1);
      issue(32'd1, 32'd1, 64'd1, 1'b0);
      drain();

      // Mid-run reset discards the in-flight product.
      issue(32'd7, 32'd9, 64'd63, 1'b0);
      repeat (9) step();
      check("run_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      sb.delete();
      step();
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_prod", prod, 64'd0);
      rst = 1'b0;
      step();
      check("in_ready_after_mid_rst", 64'(in_ready), 64'd1);
      check("no_out_valid_after_rst", 64'(out_valid), 64'd0);
      issue(32'd2, 32'd2, 64'd4, 1'b0);
      drain();

      issue(32'd0, 32'hDEADBEEF, 64'd0, 1'b0);
      drain();

      // Back-to-back with in_valid held high.
      for (int i = 0; i < 1000; i++) begin
         x = $urandom;
         y = $urandom;
         if (i % 97 == 0) x = 32'd0;
         issue(x, y, 64'(x) * 64'(y), 1'b1);
      end
      in_valid = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
